// File: rtl/rtp_audio_depacketizer.sv
// rtp_audio_depacketizer: parses RTP/UDP audio packets and unpacks big-endian
// 16-bit PCM samples into a sample FIFO. The FIFO is drained one sample per
// DAC request, and silence is returned when the FIFO runs dry.
// Optional build macro RTP_JITTER_PREFILL_EN: output stays silent until
// PREFILL samples are buffered, and again after every underrun.
module rtp_audio_depacketizer #(
  parameter int          UDP_LENGTH        = 960,
  parameter int          RTP_HEADER_LENGTH = 12,
  parameter logic [6:0]  PAYLOAD_TYPE      = 7'd0,
  parameter logic [31:0] SSRC              = 32'h12345678,
  parameter logic [15:0] SEQ_STEP          = 16'd474,
  parameter int          FIFO_AW           = 11,
  parameter int          PREFILL           = 948
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                udp_rec_data_valid,
  input  logic [7:0]          udp_rec_rdata,
  input  logic [15:0]         udp_rec_data_length,
  input  logic                wav_rden,
  output logic signed [15:0]  wav_out_data,
  output logic                wav_out_valid,
  output logic [FIFO_AW:0]    fifo_level,
  output logic [15:0]         seq_err_cnt,
  output logic [15:0]         pkt_drop_cnt,
  output logic [15:0]         ovf_cnt,
  output logic [15:0]         unf_cnt
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  localparam logic [FIFO_AW:0] DEPTH_L    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [15:0]      LAST_HDR   = 16'(RTP_HEADER_LENGTH - 1);
  localparam logic [15:0]      LAST_BYTE  = 16'(UDP_LENGTH - 1);
  localparam logic             HDR_PARITY = 1'(RTP_HEADER_LENGTH % 2);

  // A start threshold deeper than the FIFO could never be reached.
  if (PREFILL > (1 << FIFO_AW)) begin : g_prefill_check
    $error("PREFILL exceeds FIFO depth");
  end

  logic [1:0]  state_reg, state_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic        hdr_bad_reg, hdr_bad_next;
  logic [15:0] seq_reg, last_seq_reg;
  logic        first_pkt_reg;
  logic [7:0]  msb_reg;
  logic        byte_bad, push_en, drop_inc, seq_inc, accept, lsb_byte;

  // Odd payload bytes complete a sample; the header length sets the parity.
  assign lsb_byte = byte_cnt_reg[0] ^ HDR_PARITY;

  // Per-byte header field check (PT and big-endian SSRC); byte 0 is checked in IDLE.
  always_comb begin
    byte_bad = 1'b0;
    case (byte_cnt_reg)
      16'd1:   byte_bad = (udp_rec_rdata[6:0] != PAYLOAD_TYPE);
      16'd8:   byte_bad = (udp_rec_rdata != SSRC[31:24]);
      16'd9:   byte_bad = (udp_rec_rdata != SSRC[23:16]);
      16'd10:  byte_bad = (udp_rec_rdata != SSRC[15:8]);
      16'd11:  byte_bad = (udp_rec_rdata != SSRC[7:0]);
      default: byte_bad = 1'b0;
    endcase
  end

  // Packet parser: next state, byte position, and event strobes.
  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    hdr_bad_next  = hdr_bad_reg;
    push_en       = 1'b0;
    drop_inc      = 1'b0;
    seq_inc       = 1'b0;
    accept        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (udp_rec_data_valid) begin
          if (udp_rec_data_length != 16'(UDP_LENGTH)) begin
            state_next = DISCARD;
            drop_inc   = 1'b1;
          end else begin
            state_next    = HEADER;
            byte_cnt_next = 16'd1;
            hdr_bad_next  = (udp_rec_rdata[7:6] != 2'b10);
          end
        end
      end
      HEADER: begin
        if (!udp_rec_data_valid) begin
          state_next    = IDLE;
          byte_cnt_next = '0;
          drop_inc      = 1'b1;
        end else begin
          byte_cnt_next = byte_cnt_reg + 16'd1;
          hdr_bad_next  = hdr_bad_reg | byte_bad;
          if (byte_cnt_reg == LAST_HDR) begin
            if (hdr_bad_reg | byte_bad) begin
              state_next = DISCARD;
              drop_inc   = 1'b1;
            end else begin
              state_next = PAYLOAD;
              accept     = 1'b1;
              seq_inc    = !first_pkt_reg && (seq_reg != last_seq_reg + SEQ_STEP);
            end
          end
        end
      end
      PAYLOAD: begin
        if (!udp_rec_data_valid) begin
          state_next    = IDLE;
          byte_cnt_next = '0;
          drop_inc      = 1'b1;
        end else begin
          byte_cnt_next = byte_cnt_reg + 16'd1;
          push_en       = lsb_byte;
          if (byte_cnt_reg == LAST_BYTE) begin
            state_next    = IDLE;
            byte_cnt_next = '0;
          end
        end
      end
      default: begin
        byte_cnt_next = '0;
        if (!udp_rec_data_valid) state_next = IDLE;
      end
    endcase
  end

  // Parser registers; reset lands in DISCARD so a half-seen packet is skipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= DISCARD;
      byte_cnt_reg  <= '0;
      hdr_bad_reg   <= 1'b0;
      seq_reg       <= '0;
      last_seq_reg  <= '0;
      first_pkt_reg <= 1'b1;
      msb_reg       <= '0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      hdr_bad_reg  <= hdr_bad_next;
      if (state_reg == HEADER && udp_rec_data_valid &&
          (byte_cnt_reg == 16'd2 || byte_cnt_reg == 16'd3))
        seq_reg <= {seq_reg[7:0], udp_rec_rdata};
      if (state_reg == PAYLOAD && udp_rec_data_valid && !lsb_byte)
        msb_reg <= udp_rec_rdata;
      if (accept) begin
        last_seq_reg  <= seq_reg;
        first_pkt_reg <= 1'b0;
      end
    end
  end

  logic [15:0]        mem [0:(1 << FIFO_AW) - 1];
  logic [15:0]        ram_q;
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   level_reg;
  logic               served_reg, fifo_full, fifo_empty, started;
  logic               wr_ok, rd_ok, ovf_inc, unf_inc;

`ifdef RTP_JITTER_PREFILL_EN
  logic started_reg;
  assign started = started_reg;

  // Playback gate: opens at the prefill threshold, closes on any underrun.
  always_ff @(posedge clk) begin
    if (rst)
      started_reg <= 1'b0;
    else if (wav_rden && fifo_empty)
      started_reg <= 1'b0;
    else if (int'(level_reg) >= PREFILL)
      started_reg <= 1'b1;
  end
`else
  assign started = 1'b1;
`endif

  // Full/empty use the level before this cycle's read or write.
  assign fifo_full  = (level_reg == DEPTH_L);
  assign fifo_empty = (level_reg == '0);
  assign wr_ok      = push_en && !fifo_full;
  assign ovf_inc    = push_en && fifo_full;
  assign rd_ok      = wav_rden && !fifo_empty && started;
  assign unf_inc    = wav_rden && fifo_empty && started;

  // Sample storage with registered read, kept reset-free so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= {msb_reg, udp_rec_rdata};
    ram_q <= mem[rd_ptr_reg];
  end

  // FIFO pointers, occupancy and the one-cycle-late response strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      served_reg    <= 1'b0;
      wav_out_valid <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg     <= level_reg + {{FIFO_AW{1'b0}}, wr_ok} - {{FIFO_AW{1'b0}}, rd_ok};
      served_reg    <= rd_ok;
      wav_out_valid <= wav_rden;
    end
  end

  assign wav_out_data = served_reg ? $signed(ram_q) : 16'sd0;
  assign fifo_level   = level_reg;

  // Saturating statistics counters: 0 seq gap, 1 drop, 2 overflow, 3 underrun.
  logic [3:0] cnt_inc;
  assign cnt_inc = {unf_inc, ovf_inc, drop_inc, seq_inc};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [15:0] cnt_reg;
      // Count one event per cycle, holding at all-ones.
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && cnt_reg != 16'hFFFF)
          cnt_reg <= cnt_reg + 16'd1;
      end
    end
  endgenerate

  assign seq_err_cnt  = g_cnt[0].cnt_reg;
  assign pkt_drop_cnt = g_cnt[1].cnt_reg;
  assign ovf_cnt      = g_cnt[2].cnt_reg;
  assign unf_cnt      = g_cnt[3].cnt_reg;
endmodule

// File: tb/tb_rtp_audio_depacketizer.sv
// Bench for rtp_audio_depacketizer: directed scenarios plus randomized packets,
// checked cycle by cycle against a queue-based reference model.
module tb_rtp_audio_depacketizer;
  localparam int DEPTH = 512;
  localparam int PLEN  = 960;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               udp_rec_data_valid = 1'b0;
  logic [7:0]         udp_rec_rdata = '0;
  logic [15:0]        udp_rec_data_length = '0;
  logic               wav_rden = 1'b0;
  logic signed [15:0] wav_out_data;
  logic               wav_out_valid;
  logic [9:0]         fifo_level;
  logic [15:0]        seq_err_cnt, pkt_drop_cnt, ovf_cnt, unf_cnt;

  always #5 clk = ~clk;

  rtp_audio_depacketizer #(.FIFO_AW(9), .PREFILL(400)) dut (
    .clk(clk), .rst(rst),
    .udp_rec_data_valid(udp_rec_data_valid), .udp_rec_rdata(udp_rec_rdata),
    .udp_rec_data_length(udp_rec_data_length), .wav_rden(wav_rden),
    .wav_out_data(wav_out_data), .wav_out_valid(wav_out_valid),
    .fifo_level(fifo_level), .seq_err_cnt(seq_err_cnt), .pkt_drop_cnt(pkt_drop_cnt),
    .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: sample queue plus statistics.
  logic [15:0] mq[$];
  int          m_seq_err = 0, m_drop = 0, m_ovf = 0, m_unf = 0;
  bit          m_first = 1'b1;
  logic [15:0] m_last_seq = '0;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, ".seq_err"}, seq_err_cnt, m_seq_err);
    chk({tag, ".drop"}, pkt_drop_cnt, m_drop);
    chk({tag, ".ovf"}, ovf_cnt, m_ovf);
    chk({tag, ".unf"}, unf_cnt, m_unf);
    chk({tag, ".level"}, fifo_level, mq.size());
  endtask

  // One clock cycle: drive inputs, advance the model, then check the response.
  task automatic cycle(input bit v, input logic [7:0] b, input logic [15:0] len,
                       input bit rd_in, input bit push, input logic [15:0] pdata, input bit r);
    bit          rd, empty, full;
    logic [15:0] exp_rd;
    rd     = r ? 1'b0 : rd_in;
    rst    = r;
    udp_rec_data_valid  = v;
    udp_rec_rdata       = b;
    udp_rec_data_length = len;
    wav_rden            = rd;
    exp_rd = '0;
    if (r) begin
      mq.delete();
      m_seq_err = 0; m_drop = 0; m_ovf = 0; m_unf = 0;
      m_first = 1'b1;
    end else begin
      empty = (mq.size() == 0);
      full  = (mq.size() == DEPTH);
      if (rd) begin
        if (empty) m_unf = sat(m_unf);
        else exp_rd = mq.pop_front();
      end
      if (push) begin
        if (full) m_ovf = sat(m_ovf);
        else mq.push_back(pdata);
      end
    end
    tick;
    rst = 1'b0;
    chk("out_valid", wav_out_valid, rd);
    if (rd) chk("out_data", {16'd0, wav_out_data}, exp_rd);
    chk("fifo_level", fifo_level, mq.size());
  endtask

  task automatic idle(input int n, input int rd_pct);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 8'h00, 16'd0, $urandom_range(0, 99) < rd_pct, 1'b0, 16'd0, 1'b0);
  endtask

  task automatic drain;
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0);
  endtask

  // Send one packet (possibly faulty, truncated or interrupted by reset).
  task automatic send_pkt(input logic [15:0] seq, input logic [31:0] ssrc, input logic [7:0] b0,
                          input logic [15:0] len, input int nbytes, input int rd_pct,
                          input int rst_at, input bit incr, input logic [15:0] base, input int gap);
    logic [7:0]  pb [0:PLEN-1];
    logic [15:0] s;
    bit          good, alive, p;
    logic [15:0] pdata;
    pb[0] = b0; pb[1] = 8'h00; pb[2] = seq[15:8]; pb[3] = seq[7:0];
    for (int k = 4; k < 8; k++) pb[k] = 8'($urandom);
    pb[8] = ssrc[31:24]; pb[9] = ssrc[23:16]; pb[10] = ssrc[15:8]; pb[11] = ssrc[7:0];
    for (int k = 0; k < (PLEN - 12) / 2; k++) begin
      s = incr ? 16'(base + 16'(k)) : 16'($urandom);
      pb[12 + 2*k]     = s[15:8];
      pb[12 + 2*k + 1] = s[7:0];
    end
    good = (len == 16'(PLEN)) && (b0[7:6] == 2'b10) && (ssrc == 32'h12345678) && (nbytes >= 12);
    if (len != 16'(PLEN)) m_drop = sat(m_drop);
    else if (!good) m_drop = sat(m_drop);
    else begin
      if (!m_first && seq != 16'(m_last_seq + 16'd474)) m_seq_err = sat(m_seq_err);
      m_last_seq = seq;
      m_first    = 1'b0;
      if (nbytes < PLEN) m_drop = sat(m_drop);
    end
    alive = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      if (i == rst_at) alive = 1'b0;
      p = alive && good && (i >= 12) && ((i - 12) % 2 == 1);
      pdata = '0;
      if (p) pdata = {pb[i-1], pb[i]};
      cycle(1'b1, pb[i], len, $urandom_range(0, 99) < rd_pct, p, pdata, i == rst_at);
    end
    idle(gap, rd_pct);
    $display("pkt seq=%0d len=%0d bytes=%0d good=%0d level=%0d drop=%0d seq_err=%0d ovf=%0d unf=%0d",
             seq, len, nbytes, good, fifo_level, pkt_drop_cnt, seq_err_cnt, ovf_cnt, unf_cnt);
  endtask

  initial begin
    logic [15:0] sq;
    int          kind;
    // Reset
    repeat (3) tick;
    chk("rst.valid", wav_out_valid, 1'b0);
    chk("rst.data", {16'd0, wav_out_data}, 32'd0);
    check_stats("rst");
    rst = 1'b0;
    idle(2, 0);

    // Counting payload, read back in order
    send_pkt(16'd0, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b1, 16'h0001, 2);
    check_stats("pkt1");
    chk("pkt1.level474", fifo_level, 32'd474);
    drain;
    check_stats("pkt1.drained");

    // Sequence continuity, then a discontinuity
    send_pkt(16'd474, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    chk("seq.ok", seq_err_cnt, 32'd0);
    drain;
    send_pkt(16'd1000, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    chk("seq.gap", seq_err_cnt, 32'd1);
    chk("seq.gap.level", fifo_level, 32'd474);

    // Header / length faults leave the FIFO untouched
    send_pkt(16'd1474, 32'hDEADBEEF, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    chk("bad_ssrc.drop", pkt_drop_cnt, 32'd1);
    send_pkt(16'd1474, 32'h12345678, 8'h40, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    chk("bad_ver.drop", pkt_drop_cnt, 32'd2);
    send_pkt(16'd1474, 32'h12345678, 8'h80, 16'd500, 500, 0, -1, 1'b0, 16'd0, 2);
    chk("bad_len.drop", pkt_drop_cnt, 32'd3);
    chk("faults.level", fifo_level, 32'd474);
    drain;

    // Truncation after 101 payload bytes keeps 50 whole samples
    send_pkt(16'd1474, 32'h12345678, 8'h80, 16'd960, 12 + 101, 0, -1, 1'b1, 16'h0100, 2);
    chk("trunc.level", fifo_level, 32'd50);
    chk("trunc.drop", pkt_drop_cnt, 32'd4);
    drain;
    send_pkt(16'd1948, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    check_stats("after_trunc");
    drain;

    // Overflow, then underrun
    send_pkt(16'd2422, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    send_pkt(16'd2896, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b0, 16'd0, 2);
    chk("ovf.level", fifo_level, 32'd512);
    chk("ovf.cnt", ovf_cnt, 32'd436);
    drain;
    cycle(1'b0, 8'h00, 16'd0, 1'b1, 1'b0, 16'd0, 1'b0);
    chk("unf.cnt", unf_cnt, 32'd1);
    check_stats("ovf_unf");

    // Reset in mid-payload with valid held high, then a one-cycle gap
    send_pkt(16'd3370, 32'h12345678, 8'h80, 16'd960, PLEN, 0, 12 + 200, 1'b0, 16'd0, 1);
    chk("rst_mid.level", fifo_level, 32'd0);
    check_stats("rst_mid");
    send_pkt(16'd5000, 32'h12345678, 8'h80, 16'd960, PLEN, 0, -1, 1'b1, 16'h7F00, 2);
    chk("rst_mid.next_level", fifo_level, 32'd474);
    check_stats("rst_mid.next");
    drain;

    // Randomized packets with concurrent reads
    for (int n = 0; n < 10; n++) begin
      kind = $urandom_range(0, 9);
      sq = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(m_last_seq + 16'd474);
      case (kind)
        7:       send_pkt(sq, 32'h12345679, 8'h80, 16'd960, PLEN, 50, -1, 1'b0, 16'd0, $urandom_range(1, 4));
        8:       send_pkt(sq, 32'h12345678, 8'h80, 16'd960, $urandom_range(1, PLEN - 1), 50, -1, 1'b0, 16'd0, $urandom_range(1, 4));
        9:       send_pkt(sq, 32'h12345678, 8'h80, 16'($urandom_range(13, 959)), 200, 50, -1, 1'b0, 16'd0, $urandom_range(1, 4));
        default: send_pkt(sq, 32'h12345678, 8'h80, 16'd960, PLEN, $urandom_range(30, 60), -1, 1'b0, 16'd0, $urandom_range(1, 4));
      endcase
      check_stats("rand");
    end
    drain;
    idle(20, 50);
    check_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
